mem_line_responder: RTL and testbench

MEM_LINE_RESPONDER -- requirements
Module: mem_line_responder

---
 rtl/mem_line_responder.sv | 127 ++++++++++++
 tb/tb_mem_line_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_responder.sv
// Single-outstanding cache-line memory responder: accepts one line load/store,
// answers after a fixed LATENCY, and keeps a sticky flag for illegal requests.
module mem_line_responder #(
  parameter int          ADDR_W      = 32,
  parameter int          LG_CL_BYTES = 4,
  parameter int          LG_LINES    = 10,
  parameter int          TAG_W       = 2,
  parameter int          LATENCY     = 4,
  parameter logic [4:0]  OP_LOAD     = 5'd4,
  parameter logic [4:0]  OP_STORE    = 5'd7
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           mem_req_valid,
  input  logic [ADDR_W-1:0]              mem_req_addr,
  input  logic [(8<<LG_CL_BYTES)-1:0]    mem_req_store_data,
  input  logic [TAG_W-1:0]               mem_req_tag,
  input  logic [4:0]                     mem_req_opcode,
  input  logic                           mem_req_insn,
  output logic                           mem_req_ack,
  output logic                           mem_rsp_valid,
  output logic [(8<<LG_CL_BYTES)-1:0]    mem_rsp_load_data,
  output logic [TAG_W-1:0]               mem_rsp_tag,
  output logic [4:0]                     mem_rsp_opcode,
  output logic                           busy,
  output logic                           err_sticky,
  output logic [31:0]                    req_count
);

  localparam int         CL_BITS = 8 << LG_CL_BYTES;
  localparam int         LINES   = 1 << LG_LINES;
  localparam logic [7:0] LAT_M1  = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 ack_q, ack_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic [4:0]           op_q, op_d;
  logic [CL_BITS-1:0]   data_q, data_d;
  logic                 err_q, err_d;
  logic [31:0]          count_q, count_d;

  logic [CL_BITS-1:0]   mem [LINES];
  logic [LG_LINES-1:0]  line_idx;
  logic                 accept, is_load, is_store;
  logic                 unused_addr;

  // Offset and high address bits are dropped so addresses wrap over the store.
  assign line_idx    = mem_req_addr[LG_CL_BYTES+LG_LINES-1:LG_CL_BYTES];
  assign unused_addr = ^mem_req_addr;

  assign accept   = (state_q == IDLE) && mem_req_valid;
  assign is_load  = (mem_req_opcode == OP_LOAD);
  assign is_store = (mem_req_opcode == OP_STORE) && !mem_req_insn;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    tag_d   = tag_q;
    op_d    = op_q;
    data_d  = data_q;
    err_d   = err_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (mem_req_valid) begin
          ack_d   = 1'b1;
          tag_d   = mem_req_tag;
          op_d    = mem_req_opcode;
          cnt_d   = LAT_M1;
          data_d  = is_load ? mem[line_idx] : '0;
          err_d   = err_q | !(is_load | is_store);
          count_d = count_q + 32'd1;
          state_d = (LATENCY > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      tag_q   <= '0;
      op_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      tag_q   <= tag_d;
      op_q    <= op_d;
      data_q  <= data_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  // NOTE: the backing store is deliberately not reset; only the write is gated.
  always_ff @(posedge clk) begin
    if (!reset && accept && is_store) mem[line_idx] <= mem_req_store_data;
  end

  assign mem_req_ack       = ack_q;
  assign mem_rsp_valid     = (state_q == RESP);
  assign busy              = (state_q != IDLE);
  assign mem_rsp_load_data = data_q;
  assign mem_rsp_tag       = tag_q;
  assign mem_rsp_opcode    = op_q;
  assign err_sticky        = err_q;
  assign req_count         = count_q;

endmodule

// File: tb/tb_mem_line_responder.sv
// Bench for mem_line_responder: a LATENCY=4 and a LATENCY=1 instance checked
// against a timeline/line-store reference model with directed and random requests.
module tb_mem_line_responder;

  localparam int         AW  = 32;
  localparam int         LGB = 4;
  localparam int         LGL = 10;
  localparam int         TW  = 2;
  localparam int         CLB = 8 << LGB;
  localparam logic [4:0] OPL = 5'd4;
  localparam logic [4:0] OPS = 5'd7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic           valid_a = 1'b0, valid_b = 1'b0;
  logic [AW-1:0]  addr = '0;
  logic [CLB-1:0] sdata = '0;
  logic [TW-1:0]  tag = '0;
  logic [4:0]     opcode = '0;
  logic           insn = 1'b0;

  logic           ack [2], rsp [2], busy [2], err [2];
  logic [CLB-1:0] rdata [2];
  logic [TW-1:0]  rtag [2];
  logic [4:0]     rop [2];
  logic [31:0]    cnt [2];

  mem_line_responder #(.ADDR_W(AW), .LG_CL_BYTES(LGB), .LG_LINES(LGL), .TAG_W(TW),
                       .LATENCY(4), .OP_LOAD(OPL), .OP_STORE(OPS)) dut_a (
    .clk(clk), .reset(reset), .mem_req_valid(valid_a), .mem_req_addr(addr),
    .mem_req_store_data(sdata), .mem_req_tag(tag), .mem_req_opcode(opcode),
    .mem_req_insn(insn), .mem_req_ack(ack[0]), .mem_rsp_valid(rsp[0]),
    .mem_rsp_load_data(rdata[0]), .mem_rsp_tag(rtag[0]), .mem_rsp_opcode(rop[0]),
    .busy(busy[0]), .err_sticky(err[0]), .req_count(cnt[0]));

  mem_line_responder #(.ADDR_W(AW), .LG_CL_BYTES(LGB), .LG_LINES(LGL), .TAG_W(TW),
                       .LATENCY(1), .OP_LOAD(OPL), .OP_STORE(OPS)) dut_b (
    .clk(clk), .reset(reset), .mem_req_valid(valid_b), .mem_req_addr(addr),
    .mem_req_store_data(sdata), .mem_req_tag(tag), .mem_req_opcode(opcode),
    .mem_req_insn(insn), .mem_req_ack(ack[1]), .mem_rsp_valid(rsp[1]),
    .mem_rsp_load_data(rdata[1]), .mem_rsp_tag(rtag[1]), .mem_rsp_opcode(rop[1]),
    .busy(busy[1]), .err_sticky(err[1]), .req_count(cnt[1]));

  // Reference model: line contents keyed by (instance, line), plus counters.
  logic [CLB-1:0] model_mem [int];
  int unsigned    m_count [2];
  bit             m_err [2];
  bit             in_resp [2];
  int             checks = 0;
  int             errors = 0;

  task automatic check(input string name, input logic [CLB-1:0] obs, input logic [CLB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic set_valid(input int sel, input logic v);
    if (sel == 1) valid_b = v;
    else          valid_a = v;
  endtask

  // Issue one request just after a falling edge. A request accepted at edge E
  // acks in the cycle after E and responds in the cycle starting at edge E+lat-1.
  // With chain=1 valid stays high into the response cycle for the next call.
  task automatic do_req(input int sel, input logic [AW-1:0] a, input logic [CLB-1:0] d,
                        input logic [TW-1:0] t, input logic [4:0] o, input logic in,
                        input bit chain);
    int lat;
    int key;
    bit ld, st;
    logic [CLB-1:0] exp_data;
    lat = (sel == 1) ? 1 : 4;
    addr = a; sdata = d; tag = t; opcode = o; insn = in;
    set_valid(sel, 1'b1);
    if (in_resp[sel]) begin
      @(negedge clk);
      check("resp_cycle_req_ignored_ack", ack[sel], 0);
      check("resp_cycle_req_ignored_busy", busy[sel], 0);
      check("resp_cycle_req_ignored_count", cnt[sel], m_count[sel]);
      in_resp[sel] = 0;
    end
    key = sel * (1 << LGL) + int'(a[LGB+LGL-1:LGB]);
    ld  = (o == OPL);
    st  = (o == OPS) && !in;
    exp_data = '0;
    if (ld && model_mem.exists(key)) exp_data = model_mem[key];
    if (st) model_mem[key] = d;
    if (!ld && !st) m_err[sel] = 1;
    m_count[sel]++;
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      check("ack", ack[sel], (k == 0));
      check("rsp_valid", rsp[sel], (k == lat - 1));
      check("busy", busy[sel], 1);
      if (k == 0) begin
        check("req_count", cnt[sel], m_count[sel]);
        check("err_sticky", err[sel], m_err[sel]);
      end
      if (k == lat - 1) begin
        check("rsp_data", rdata[sel], exp_data);
        check("rsp_tag", rtag[sel], t);
        check("rsp_opcode", rop[sel], o);
      end
    end
    if (chain) in_resp[sel] = 1;
    else begin
      set_valid(sel, 1'b0);
      @(negedge clk);
      check("idle_busy", busy[sel], 0);
      check("idle_rsp_valid", rsp[sel], 0);
      check("idle_ack", ack[sel], 0);
    end
  endtask

  function automatic logic [AW-1:0] rand_addr(input int line);
    logic [AW-1:0] r;
    r = $urandom;
    r[LGB+LGL-1:LGB] = LGL'(line);
    return r;
  endfunction

  function automatic logic [CLB-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  int lines [8];

  initial begin
    logic [CLB-1:0] d;
    logic [4:0]     o;
    int             r;
    bit             ch;

    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("reset_ack", ack[s], 0);
      check("reset_rsp_valid", rsp[s], 0);
      check("reset_busy", busy[s], 0);
      check("reset_err", err[s], 0);
      check("reset_count", cnt[s], 0);
      check("reset_data", rdata[s], 0);
      check("reset_tag", rtag[s], 0);
      check("reset_opcode", rop[s], 0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Store then load of line 0x40, then aliased load across the store size.
    do_req(0, 32'h40, 128'hDEADBEEF, 2'd1, OPS, 1'b0, 1'b0);
    do_req(0, 32'h40, '0, 2'd2, OPL, 1'b0, 1'b0);
    do_req(0, 32'h4F + (32'd1 << (LGB + LGL)), '0, 2'd3, OPL, 1'b1, 1'b0);

    // Valid held through the response with the next request presented there.
    do_req(0, 32'h100, 128'h1234_5678_9abc_def0_0f1e_2d3c_4b5a_6978, 2'd3, OPS, 1'b0, 1'b1);
    do_req(0, 32'h100, '0, 2'd0, OPL, 1'b0, 1'b0);

    // Illegal requests: no write, zero data, sticky error.
    do_req(0, 32'h80, 128'hCAFE_F00D, 2'd0, OPS, 1'b0, 1'b0);
    do_req(0, 32'h80, 128'h5555_AAAA, 2'd1, OPS, 1'b1, 1'b0);
    do_req(0, 32'h80, 128'h7777_8888, 2'd2, 5'd9, 1'b0, 1'b0);
    do_req(0, 32'h80, '0, 2'd3, OPL, 1'b0, 1'b0);

    // LATENCY=1 instance, back-to-back requests with valid held.
    do_req(1, 32'h40, 128'hB0B0_1111, 2'd1, OPS, 1'b0, 1'b1);
    do_req(1, 32'h40, '0, 2'd2, OPL, 1'b0, 1'b1);
    do_req(1, 32'h40, '0, 2'd3, OPL, 1'b1, 1'b0);

    // Reset while a store is in WAIT: aborted, but the write already happened.
    d = 128'hFEED_0000_0000_0000_0000_0000_0000_BEEF;
    addr = 32'h3000; sdata = d; tag = 2'd1; opcode = OPS; insn = 1'b0;
    valid_a = 1'b1;
    model_mem[int'(addr[LGB+LGL-1:LGB])] = d;
    m_count[0]++;
    @(negedge clk);
    check("pre_reset_ack", ack[0], 1);
    check("pre_reset_count", cnt[0], m_count[0]);
    valid_a = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      m_count[s] = 0;
      m_err[s] = 0;
      in_resp[s] = 0;
    end
    check("mid_reset_busy", busy[0], 0);
    check("mid_reset_count", cnt[0], 0);
    check("mid_reset_err", err[0], 0);
    check("mid_reset_rsp_valid", rsp[0], 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("post_reset_no_rsp", rsp[0], 0);
    end
    do_req(0, 32'h3000, '0, 2'd2, OPL, 1'b0, 1'b0);

    // Random traffic over a small set of lines with random alias/offset bits.
    for (int j = 0; j < 8; j++) begin
      lines[j] = (j * 131 + 7) % (1 << LGL);
      do_req(0, rand_addr(lines[j]), rand_line(), 2'(j), OPS, 1'b0, 1'b0);
      do_req(1, rand_addr(lines[j]), rand_line(), 2'(j), OPS, 1'b0, 1'b0);
    end
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 30; i++) begin
        r  = $urandom_range(0, 9);
        ch = (i != 29) && ($urandom_range(0, 1) == 1);
        if (r < 5)       o = OPL;
        else if (r < 9)  o = OPS;
        else begin
          o = 5'($urandom_range(0, 31));
          while (o == OPL || o == OPS) o = 5'($urandom_range(0, 31));
        end
        do_req(s, rand_addr(lines[$urandom_range(0, 7)]), rand_line(),
               2'($urandom_range(0, 3)), o, (r == 8), ch);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
